// File: rtl/osc_pkg.sv
// osc_pkg: shared state encoding and ring period for the Johnson oscillator sequencer
package osc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_STAGES = 2;
  localparam int PERIOD = 2 * DEF_STAGES;
endpackage

// File: rtl/johnson_ring.sv
// johnson_ring: STAGES-bit twisted-ring of D flops with seed load and advance enable
module johnson_ring #(
  parameter int STAGES = 2,
  parameter logic [STAGES-1:0] RST_PHASE = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [STAGES-1:0] seed,
  output logic [STAGES-1:0] phase
);
  // load wins over advance; the inverted top bit feeds back into bit 0
  always_ff @(posedge clk or posedge rst)
    if (rst) phase <= RST_PHASE;
    else if (load) phase <= seed;
    else if (en) phase <= {phase[STAGES-2:0], ~phase[STAGES-1]};
endmodule

// File: rtl/osc_sequencer.sv
// osc_sequencer: burst/free-run controller for the Johnson ring oscillator
module osc_sequencer
  import osc_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W = 8,
  parameter logic [STAGES-1:0] RST_PHASE = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [STAGES-1:0] seed,
  output logic [STAGES-1:0] phase,
  output logic              ix,
  output logic              y,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  periods
);
  localparam int PER = (STAGES == DEF_STAGES) ? PERIOD : 2 * STAGES;
  localparam int SW = $clog2(PER);
  state_t state;
  logic [SW-1:0] step;
  logic [CNT_W-1:0] len;
  logic load, en, wrap;
  assign load = (state == IDLE) && start && !stop;
  assign en = (state == RUN) && !stop;
  assign wrap = step == SW'(PER - 1);
  assign ix = phase[0];
  assign y = phase[STAGES-1];
  johnson_ring #(.STAGES(STAGES), .RST_PHASE(RST_PHASE)) u_ring (
    .clk(clk), .rst(rst), .load(load), .en(en), .seed(seed), .phase(phase)
  );
  // sequencing FSM with step/period counters, length latch and registered Moore flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      step <= '0;
      periods <= '0;
      len <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !stop) begin
          len <= burst_len;
          step <= '0;
          periods <= '0;
          state <= RUN;
          busy <= 1'b1;
        end
        RUN: if (stop) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          step <= wrap ? '0 : step + 1'b1;
          if (wrap) begin
            periods <= periods + 1'b1;
            if (len != '0 && periods + 1'b1 == len) begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_osc_sequencer.sv
// tb_osc_sequencer: directed self-checking bench for osc_sequencer (STAGES=2, CNT_W=8)
module tb_osc_sequencer;
  logic clk = 1'b0;
  logic rst, start, stop;
  logic [7:0] burst_len, periods;
  logic [1:0] seed, phase;
  logic ix, y, busy, done;
  int checks = 0;
  int failures = 0;
  int done_seen;
  logic [1:0] p;

  osc_sequencer #(.STAGES(2), .CNT_W(8), .RST_PHASE(2'b10)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .burst_len(burst_len),
    .seed(seed), .phase(phase), .ix(ix), .y(y), .busy(busy), .done(done),
    .periods(periods)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [1:0] adv(input logic [1:0] v);
    return {v[0], ~v[1]};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; burst_len = 8'd0; seed = 2'b00;
    #3;
    check("rst_phase", phase, 2'b10);
    check("rst_ix", ix, 1'b0);
    check("rst_y", y, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_periods", periods, 8'd0);
    tick; rst = 1'b0;
    tick;
    check("idle_hold_phase", phase, 2'b10);

    // burst of 3 periods from seed 00, with ignored start/len change mid-run
    seed = 2'b00; burst_len = 8'd3; start = 1'b1;
    tick; start = 1'b0;
    check("b3_load", phase, 2'b00);
    check("b3_busy0", busy, 1'b1);
    p = 2'b00; done_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 5) begin start = 1'b1; seed = 2'b11; burst_len = 8'd7; end
      if (i == 6) start = 1'b0;
      tick;
      p = adv(p);
      check($sformatf("b3_phase%0d", i), phase, p);
      if (i < 12) begin
        check($sformatf("b3_busy%0d", i), busy, 1'b1);
        done_seen += int'(done);
      end
    end
    check("b3_nodone_early", done_seen, 0);
    check("b3_done", done, 1'b1);
    check("b3_busy_done", busy, 1'b0);
    check("b3_periods", periods, 8'd3);
    check("b3_phase_final", phase, 2'b00);
    start = 1'b1;
    tick; start = 1'b0;
    check("done_start_ignored_busy", busy, 1'b0);
    check("done_cleared", done, 1'b0);
    check("done_phase_hold", phase, 2'b00);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1; seed = 2'b01;
    tick; start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 1'b0);
    check("ss_phase", phase, 2'b00);

    // free-run for 260 periods, counter wraps to 4
    seed = 2'b00; burst_len = 8'd0; start = 1'b1;
    tick; start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 1040; i++) begin
      tick;
      done_seen += int'(done);
    end
    check("fr_busy", busy, 1'b1);
    stop = 1'b1;
    tick; stop = 1'b0;
    check("fr_stop_busy", busy, 1'b0);
    check("fr_periods", periods, 8'd4);
    check("fr_phase", phase, 2'b00);
    check("fr_nodone", done_seen + int'(done), 0);

    // abort mid-burst: seed 01, 7 advances then stop
    seed = 2'b01; burst_len = 8'd5; start = 1'b1;
    tick; start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 7; i++) begin
      tick;
      done_seen += int'(done);
    end
    check("ab_phase_before", phase, 2'b00);
    stop = 1'b1;
    tick; stop = 1'b0;
    check("ab_busy", busy, 1'b0);
    check("ab_phase", phase, 2'b00);
    check("ab_periods", periods, 8'd1);
    tick;
    check("ab_phase_frozen", phase, 2'b00);
    check("ab_periods_frozen", periods, 8'd1);
    check("ab_nodone", done_seen + int'(done), 0);

    // single period, then back-to-back start with a new seed
    seed = 2'b00; burst_len = 8'd1; start = 1'b1;
    tick; start = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    check("b1_not_done_yet", done, 1'b0);
    tick;
    check("b1_done", done, 1'b1);
    check("b1_periods", periods, 8'd1);
    tick;
    check("b1_idle", busy, 1'b0);
    seed = 2'b11; start = 1'b1;
    tick; start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    check("b2b_seed", phase, 2'b11);
    check("b2b_periods_clr", periods, 8'd0);
    tick;
    check("b2b_adv1", phase, 2'b10);
    check("b2b_ix", ix, 1'b0);
    check("b2b_y", y, 1'b1);
    tick; tick; tick;
    check("b2b_done", done, 1'b1);
    check("b2b_phase", phase, 2'b11);

    // asynchronous reset mid-run, between clock edges
    tick;
    seed = 2'b01; burst_len = 8'd2; start = 1'b1;
    tick; start = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    check("arst_phase", phase, 2'b10);
    check("arst_busy", busy, 1'b0);
    check("arst_periods", periods, 8'd0);
    check("arst_done", done, 1'b0);
    tick; rst = 1'b0;
    tick;
    check("arst_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
